// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_DIV   = 3'd4,
    OP_DIVU  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  // Ops that iterate on operand magnitudes and fix the sign at the end.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Bit-serial datapath: shift-add multiply or restoring divide, one bit per clock.
// Multiply: lo holds the multiplier and fills with product low bits, hi accumulates.
// Divide:   lo holds the dividend and fills with quotient bits, hi is the remainder.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quo_o,
  output logic [WIDTH-1:0]   rem_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;

  // Next-state for one iteration step, or operand load on accept.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[WIDTH-1:0] - b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (load_i) begin
      hi_d  = '0;
      lo_d  = a_mag_i;
      b_d   = b_mag_i;
      cnt_d = CNT_W'(WIDTH);
    end else if (step_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      if (div_i) begin
        // When the trial subtract fits, the difference is below the divisor, so W bits suffice.
        hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign prod_o = {hi_q, lo_q};
  assign quo_o  = lo_q;
  assign rem_o  = hi_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the MIPS EX stage: control FSM, sign handling and result write-back.
// Handshake: Start is taken only in IDLE (Busy==0); Busy rises the cycle after an iterative
// op is accepted and falls with the one-cycle Done pulse, when Hi/Lo already hold the result.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output state_e           DbgState
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, hi_q, lo_q, hi_d, lo_d;
  logic             a_neg_q, b_neg_q, divz_q;
  logic             busy_q, done_q, dbz_q;

  logic             accept, load, sgn, is_div, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic               core_last;
  logic [2*WIDTH-1:0] core_prod, prod_s;
  logic [WIDTH-1:0]   core_quo, core_rem, quo_s, rem_s;

  assign accept = (state_q == S_IDLE) && Start;
  assign sgn    = op_is_signed(Op);
  assign is_div = (Op == OP_DIV) || (Op == OP_DIVU);
  assign b_zero = (B == '0);
  assign a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (sgn && B[WIDTH-1]) ? -B : B;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          load = 1'b1;
          if (Op <= OP_MSUB)        state_d = S_MUL;
          else if (is_div && !b_zero) state_d = S_DIV;
          else                      state_d = S_FIN;
        end
      end
      S_MUL, S_DIV: if (core_last) state_d = S_FIN;
      S_FIN:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  muldiv_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .load_i  (load),
    .step_i  ((state_q == S_MUL) || (state_q == S_DIV)),
    .div_i   (state_q == S_DIV),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .last_o  (core_last),
    .prod_o  (core_prod),
    .quo_o   (core_quo),
    .rem_o   (core_rem)
  );

  // Sign fix-up and the Hi/Lo value written in FIN; accumulate reads Hi/Lo as they are now.
  always_comb begin
    prod_s = (a_neg_q ^ b_neg_q) ? -core_prod : core_prod;
    quo_s  = (a_neg_q ^ b_neg_q) ? -core_quo  : core_quo;
    rem_s  = a_neg_q ? -core_rem : core_rem;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_s;
      OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
      OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
      OP_DIV, OP_DIVU:   if (!divz_q) {hi_d, lo_d} = {rem_s, quo_s};
      OP_MTHI:           hi_d = a_q;
      OP_MTLO:           lo_d = a_q;
      default: ;
    endcase
  end

  // State, latched operation context and Hi/Lo.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      divz_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      if (accept) begin
        op_q    <= op_e'(Op);
        a_q     <= A;
        a_neg_q <= sgn && A[WIDTH-1];
        b_neg_q <= sgn && B[WIDTH-1];
        divz_q  <= is_div && b_zero;
        busy_q  <= (Op <= OP_MSUB) || (is_div && !b_zero);
      end
      if (state_q == S_FIN) begin
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        busy_q <= 1'b0;
        done_q <= 1'b1;
        dbz_q  <= divz_q;
      end
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;
  state_e      DbgState;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo),
    .DbgState(DbgState)
  );

  // Clock.
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [64:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural Hi/Lo.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [64:0] exp);
    int       sa, sb;
    longint   la, lb;
    logic [63:0] p, acc;
    logic     dbz;
    sa = a; sb = b; la = sa; lb = sb;
    dbz = 1'b0;
    acc = {hi_m, lo_m};
    case (op)
      3'd0: {hi_m, lo_m} = la * lb;
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = p; end
      3'd2: {hi_m, lo_m} = acc + 64'(la * lb);
      3'd3: {hi_m, lo_m} = acc - 64'(la * lb);
      3'd4: begin
        if (b == 0) dbz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo_m = a; hi_m = 0; end
        else begin lo_m = sa / sb; hi_m = sa % sb; end
      end
      3'd5: begin
        if (b == 0) dbz = 1'b1;
        else begin lo_m = a / b; hi_m = a % b; end
      end
      3'd6: hi_m = a;
      default: lo_m = a;
    endcase
    exp = {dbz, hi_m, lo_m};
  endtask

  // Issue one op and follow it to Done; optionally pulse Start mid-flight.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    logic [64:0] exp;
    int lat_exp, k;
    model(op, a, b, exp);
    exp_q.push_back(exp);
    lat_exp = (op <= 3'd3 || ((op == 3'd4 || op == 3'd5) && b != 0)) ? 34 : 2;
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk); k = 1;
    Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
    check_eq("busy_after_start", 64'(Busy), 64'(lat_exp == 34));
    while (!Done && k < 200) begin
      if (poke && k == 5) begin Start = 1'b1; Op = OP_MTLO; A = $urandom; end
      else Start = 1'b0;
      @(negedge Clk); k++;
    end
    Start = 1'b0;
    check_eq("latency", 64'(k), 64'(lat_exp));
    if (Done) begin
      exp = exp_q.pop_front();
      check_eq("hi", 64'(Hi), 64'(exp[63:32]));
      check_eq("lo", 64'(Lo), 64'(exp[31:0]));
      check_eq("divbyzero", 64'(DivByZero), 64'(exp[64]));
      check_eq("busy_at_done", 64'(Busy), 64'd0);
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge Clk);
    check_eq("done_one_cycle", 64'(Done), 64'd0);
    check_eq("dbz_one_cycle", 64'(DivByZero), 64'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Stimulus.
  initial begin
    int k, done_seen;
    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    check_eq("rst_hi", 64'(Hi), 64'd0);
    check_eq("rst_lo", 64'(Lo), 64'd0);
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_done", 64'(Done), 64'd0);
    check_eq("rst_dbz", 64'(DivByZero), 64'd0);
    check_eq("rst_state", 64'(DbgState), 64'(S_IDLE));
    Reset = 1'b0;
    @(negedge Clk);

    run_op(3'd0, -32'sd3, 32'd7, 1'b0);
    check_eq("mult_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check_eq("multu_const", {32'(Hi), 32'(Lo)}, 64'h0000_0001_FFFF_FFFE);
    run_op(3'd7, 32'd5, 32'd0, 1'b0);
    run_op(3'd6, 32'd0, 32'd0, 1'b0);
    run_op(3'd2, 32'd4, 32'd6, 1'b0);
    check_eq("madd_const", {32'(Hi), 32'(Lo)}, 64'd29);
    run_op(3'd3, 32'd10, 32'd3, 1'b0);
    check_eq("msub_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(3'd4, -32'sd7, 32'd2, 1'b0);
    check_eq("div_const", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd5, 32'd7, 32'd0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("divmin_const", {32'(Hi), 32'(Lo)}, 64'h0000_0000_8000_0000);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), bit'($urandom_range(0, 1)));

    // Reset in the middle of an iteration aborts with no Done and clears Hi/Lo.
    Start = 1'b1; Op = OP_MULT; A = 32'd12345; B = 32'd678;
    @(negedge Clk); k = 1; Start = 1'b0;
    while (k < 10) begin @(negedge Clk); k++; end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check_eq("abort_busy", 64'(Busy), 64'd0);
    check_eq("abort_hi", 64'(Hi), 64'(hi_m));
    check_eq("abort_lo", 64'(Lo), 64'(lo_m));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    run_op(3'd1, 32'd9, 32'd9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
